// File: rtl/wb_text_writer.sv
// Wishbone write-side controller for the 80-column text display: cursor, auto-advance, clear/home/newline, font loading.
// Optional clear-complete interrupt is compiled in with `define WB_TEXT_WRITER_IRQ_EN.
module wb_text_writer #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 25,
   parameter logic [7:0]  FILL0 = 8'h20
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_wb_cyc,
   input  logic        I_wb_stb,
   input  logic        I_wb_we,
   input  logic [2:0]  I_wb_adr,
   input  logic [7:0]  I_wb_dat,
   output logic [7:0]  O_wb_dat,
   output logic        O_wb_ack,
   output logic        O_char_we,
   output logic [10:0] O_char_addr,
   output logic [7:0]  O_char_data,
   output logic        O_font_we,
   output logic [5:0]  O_font_addr,
`ifdef WB_TEXT_WRITER_IRQ_EN
   output logic        O_irq,
`endif
   output logic [7:0]  O_font_data
);

   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);
   localparam int NCELL = COLS * ROWS;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t         r_state, w_state_nxt;
   logic           r_ack, r_char_we, r_font_we;
   logic [7:0]     r_rdata, r_char_data, r_font_data, r_fill;
   logic [10:0]    r_char_addr;
   logic [5:0]     r_font_addr, r_font_a;
   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   logic           w_req, w_busy, w_stall, w_acc, w_wr, w_clr_start, w_clr_last, w_irq_bit;
   logic [7:0]     w_rdata;
   logic [10:0]    w_cur_addr;
   logic [XW-1:0]  w_x_wr;
   logic [YW-1:0]  w_y_wr, w_y_inc;

   // Only DATA and CMD writes touch the cursor/char port, so only they wait out a clear.
   assign w_req      = I_wb_cyc & I_wb_stb & ~r_ack;
   assign w_busy     = (r_state == ST_CLEAR);
   assign w_stall    = w_busy & I_wb_we & ((I_wb_adr == 3'd0) | (I_wb_adr == 3'd3));
   assign w_acc      = w_req & ~w_stall;
   assign w_wr       = w_acc & I_wb_we;
   assign w_clr_last = w_busy & (r_char_addr == 11'(NCELL - 1));
   assign w_cur_addr = 11'(r_y) * 11'(COLS) + 11'(r_x);
   assign w_x_wr     = (I_wb_dat >= 8'(COLS)) ? XW'(COLS - 1) : I_wb_dat[XW-1:0];
   assign w_y_wr     = (I_wb_dat >= 8'(ROWS)) ? YW'(ROWS - 1) : I_wb_dat[YW-1:0];
   assign w_y_inc    = (r_y == YW'(ROWS - 1)) ? '0 : r_y + YW'(1);

`ifdef WB_TEXT_WRITER_IRQ_EN
   logic r_irq;
   assign w_irq_bit = r_irq;
   assign O_irq     = r_irq;

   // Completion set has priority over the read-to-clear.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         r_irq <= 1'b0;
      end else if (w_clr_last) begin
         r_irq <= 1'b1;
      end else if (w_acc && !I_wb_we && (I_wb_adr == 3'd7)) begin
         r_irq <= 1'b0;
      end
   end
`else
   assign w_irq_bit = 1'b0;
`endif

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr && (I_wb_adr == 3'd3) && (I_wb_dat == 8'h01)) begin
               w_state_nxt = ST_CLEAR;
               w_clr_start = 1'b1;
            end
         end
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = 8'h00;
      case (I_wb_adr)
         3'd1:    w_rdata = 8'(r_x);
         3'd2:    w_rdata = 8'(r_y);
         3'd4:    w_rdata = {2'b00, r_font_a};
         3'd6:    w_rdata = r_fill;
         3'd7:    w_rdata = {6'b000000, w_irq_bit, w_busy};
         default: w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         r_ack       <= 1'b0;
         r_rdata     <= 8'h00;
         r_char_we   <= 1'b0;
         r_char_addr <= '0;
         r_char_data <= 8'h00;
         r_font_we   <= 1'b0;
         r_font_addr <= '0;
         r_font_data <= 8'h00;
         r_font_a    <= '0;
         r_fill      <= FILL0;
         r_x         <= '0;
         r_y         <= '0;
      end else begin
         r_ack     <= w_acc;
         r_char_we <= 1'b0;
         r_font_we <= 1'b0;
         if (w_acc) r_rdata <= I_wb_we ? 8'h00 : w_rdata;
         // The clear walks r_char_addr itself; its data stays as latched at entry.
         if (w_busy && !w_clr_last) begin
            r_char_we   <= 1'b1;
            r_char_addr <= r_char_addr + 11'd1;
         end
         if (w_clr_start) begin
            r_char_we   <= 1'b1;
            r_char_addr <= '0;
            r_char_data <= r_fill;
         end
         if (w_wr) begin
            case (I_wb_adr)
               3'd0: begin
                  r_char_we   <= 1'b1;
                  r_char_addr <= w_cur_addr;
                  r_char_data <= I_wb_dat;
                  if (r_x == XW'(COLS - 1)) begin
                     r_x <= '0;
                     r_y <= w_y_inc;
                  end else begin
                     r_x <= r_x + XW'(1);
                  end
               end
               3'd1: r_x <= w_x_wr;
               3'd2: r_y <= w_y_wr;
               3'd3: begin
                  if (I_wb_dat == 8'h02) begin
                     r_x <= '0;
                     r_y <= '0;
                  end else if (I_wb_dat == 8'h03) begin
                     r_x <= '0;
                     r_y <= w_y_inc;
                  end
               end
               3'd4: r_font_a <= I_wb_dat[5:0];
               3'd5: begin
                  r_font_we   <= 1'b1;
                  r_font_addr <= r_font_a;
                  r_font_data <= I_wb_dat;
                  r_font_a    <= r_font_a + 6'd1;
               end
               3'd6: r_fill <= I_wb_dat;
               default: ;
            endcase
         end
         if (w_clr_last) begin
            r_x <= '0;
            r_y <= '0;
         end
      end
   end

   assign O_wb_dat    = r_rdata;
   assign O_wb_ack    = r_ack;
   assign O_char_we   = r_char_we;
   assign O_char_addr = r_char_addr;
   assign O_char_data = r_char_data;
   assign O_font_we   = r_font_we;
   assign O_font_addr = r_font_addr;
   assign O_font_data = r_font_data;

endmodule

// File: tb/tb_wb_text_writer.sv
// Directed bench for wb_text_writer: register access, cursor wrap, clear sequence, font pointer, reset abort.
// Builds with or without `define WB_TEXT_WRITER_IRQ_EN.
module tb_wb_text_writer;

   localparam int NCELL = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [2:0]  adr;
   logic [7:0]  dat;
   logic [7:0]  o_dat;
   logic        o_ack, o_char_we, o_font_we;
   logic [10:0] o_char_addr;
   logic [7:0]  o_char_data, o_font_data;
   logic [5:0]  o_font_addr;
`ifdef WB_TEXT_WRITER_IRQ_EN
   logic        o_irq;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   logic        cap_char_we, cap_font_we;
   logic [10:0] cap_char_addr;
   logic [7:0]  cap_char_data, cap_font_data, cap_rdata;
   logic [5:0]  cap_font_addr;
   int          cap_wait, cap_ack_cyc;
   int          t0;

   wb_text_writer dut (
      .I_clk       (clk),
      .I_rst       (rst),
      .I_wb_cyc    (cyc),
      .I_wb_stb    (stb),
      .I_wb_we     (we),
      .I_wb_adr    (adr),
      .I_wb_dat    (dat),
      .O_wb_dat    (o_dat),
      .O_wb_ack    (o_ack),
      .O_char_we   (o_char_we),
      .O_char_addr (o_char_addr),
      .O_char_data (o_char_data),
      .O_font_we   (o_font_we),
      .O_font_addr (o_font_addr),
`ifdef WB_TEXT_WRITER_IRQ_EN
      .O_irq       (o_irq),
`endif
      .O_font_data (o_font_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One Wishbone access; captures everything visible in the ack cycle.
   task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d);
      int n;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!o_ack && n < 3000);
      chk("ack_seen", 32'(o_ack), 1);
      cap_wait      = n;
      cap_ack_cyc   = cyc_cnt;
      cap_rdata     = o_dat;
      cap_char_we   = o_char_we;
      cap_char_addr = o_char_addr;
      cap_char_data = o_char_data;
      cap_font_we   = o_font_we;
      cap_font_addr = o_font_addr;
      cap_font_data = o_font_data;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wb_xfer(1'b1, a, d);
   endtask

   task automatic rd(input logic [2:0] a);
      wb_xfer(1'b0, a, 8'h00);
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; dat = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_char_we", 32'(o_char_we), 0);
      chk("rst_ack", 32'(o_ack), 0);
      chk("rst_char_addr", 32'(o_char_addr), 0);
      chk("rst_font_we", 32'(o_font_we), 0);
      chk("rst_wb_dat", 32'(o_dat), 0);
      rst = 1'b0;
      rd(3'd6);  chk("rst_fill", 32'(cap_rdata), 32'h20);
      rd(3'd1);  chk("rst_cur_x", 32'(cap_rdata), 0);

      // 1: first character lands at cell 0, cursor advances
      wr(3'd0, 8'h41);
      chk("t1_we", 32'(cap_char_we), 1);
      chk("t1_addr", 32'(cap_char_addr), 0);
      chk("t1_data", 32'(cap_char_data), 32'h41);
      chk("t1_wait", 32'(cap_wait), 1);
      @(posedge clk); #1;
      chk("t1_we_single", 32'(o_char_we), 0);
      rd(3'd1);  chk("t1_cur_x", 32'(cap_rdata), 1);
      rd(3'd0);  chk("t1_data_rd", 32'(cap_rdata), 0);

      // 2: end-of-row and end-of-screen wrap
      wr(3'd1, 8'd79); wr(3'd2, 8'd0); wr(3'd0, 8'h42);
      chk("t2_addr79", 32'(cap_char_addr), 79);
      chk("t2_data", 32'(cap_char_data), 32'h42);
      rd(3'd1);  chk("t2_x", 32'(cap_rdata), 0);
      rd(3'd2);  chk("t2_y", 32'(cap_rdata), 1);
      wr(3'd1, 8'd79); wr(3'd2, 8'd24); wr(3'd0, 8'h43);
      chk("t2_addr1999", 32'(cap_char_addr), 1999);
      rd(3'd1);  chk("t2_wrap_x", 32'(cap_rdata), 0);
      rd(3'd2);  chk("t2_wrap_y", 32'(cap_rdata), 0);

      // 3: full clear with concurrent bus traffic
      wr(3'd6, 8'h2E);
      wr(3'd3, 8'h01);
      t0 = cap_ack_cyc;
      chk("t3_cmd_wait", 32'(cap_wait), 1);
      chk("t3_c0_we", 32'(cap_char_we), 1);
      chk("t3_c0_addr", 32'(cap_char_addr), 0);
      chk("t3_c0_data", 32'(cap_char_data), 32'h2E);
      fork
         begin
            int bad;
            bad = 0;
            for (int i = 1; i < NCELL; i++) begin
               @(posedge clk); #1;
               if (o_char_we !== 1'b1 || o_char_addr !== 11'(i) || o_char_data !== 8'h2E) bad++;
            end
            chk("t3_clear_run_bad", 32'(bad), 0);
            @(posedge clk); #1;
            chk("t3_clear_end_we", 32'(o_char_we), 0);
`ifdef WB_TEXT_WRITER_IRQ_EN
            chk("t3_irq_set", 32'(o_irq), 1);
`endif
         end
         begin
            repeat (50) @(posedge clk);
            rd(3'd7);  chk("t3_status_busy", 32'(cap_rdata), 32'h01);
            wr(3'd6, 8'h55);
            chk("t3_fill_wait", 32'(cap_wait), 1);
            rd(3'd6);  chk("t3_fill_rd", 32'(cap_rdata), 32'h55);
            rd(3'd7);  chk("t3_status_busy2", 32'(cap_rdata), 32'h01);
            wr(3'd0, 8'h44);
            chk("t3_data_ack_cyc", 32'(cap_ack_cyc - t0), 2001);
            chk("t3_data_addr", 32'(cap_char_addr), 0);
            chk("t3_data_data", 32'(cap_char_data), 32'h44);
         end
      join
      rd(3'd1);  chk("t3_x_after", 32'(cap_rdata), 1);
      rd(3'd2);  chk("t3_y_after", 32'(cap_rdata), 0);
`ifdef WB_TEXT_WRITER_IRQ_EN
      chk("t3_irq_held", 32'(o_irq), 1);
      rd(3'd7);  chk("t3_status_irq", 32'(cap_rdata), 32'h02);
      chk("t3_irq_cleared", 32'(o_irq), 0);
`endif
      rd(3'd7);  chk("t3_status_idle", 32'(cap_rdata), 0);

      // 4: font pointer wrap
      wr(3'd4, 8'd63);
      wr(3'd5, 8'h1F);
      chk("t4_f0_we", 32'(cap_font_we), 1);
      chk("t4_f0_addr", 32'(cap_font_addr), 63);
      chk("t4_f0_data", 32'(cap_font_data), 32'h1F);
      wr(3'd5, 8'h11);
      chk("t4_f1_addr", 32'(cap_font_addr), 0);
      chk("t4_f1_data", 32'(cap_font_data), 32'h11);
      rd(3'd4);  chk("t4_font_a", 32'(cap_rdata), 1);

      // 5: clamping and commands
      wr(3'd1, 8'd100); rd(3'd1); chk("t5_clamp_x", 32'(cap_rdata), 79);
      wr(3'd2, 8'd40);  rd(3'd2); chk("t5_clamp_y", 32'(cap_rdata), 24);
      wr(3'd3, 8'h03);
      rd(3'd1);  chk("t5_nl_x", 32'(cap_rdata), 0);
      rd(3'd2);  chk("t5_nl_y", 32'(cap_rdata), 0);
      wr(3'd1, 8'd5); wr(3'd2, 8'd3);
      wr(3'd3, 8'h7F);
      chk("t5_nop_we", 32'(cap_char_we), 0);
      rd(3'd1);  chk("t5_nop_x", 32'(cap_rdata), 5);
      rd(3'd2);  chk("t5_nop_y", 32'(cap_rdata), 3);
      wr(3'd3, 8'h03);
      rd(3'd2);  chk("t5_nl_y4", 32'(cap_rdata), 4);
      wr(3'd3, 8'h02);
      rd(3'd1);  chk("t5_home_x", 32'(cap_rdata), 0);
      rd(3'd2);  chk("t5_home_y", 32'(cap_rdata), 0);

      // 6: reset aborts a clear in progress
      wr(3'd3, 8'h01);
      repeat (500) @(posedge clk);
      #1;
      chk("t6_c500_we", 32'(o_char_we), 1);
      chk("t6_c500_addr", 32'(o_char_addr), 500);
      rst = 1'b1;
      #1;
      chk("t6_rst_we", 32'(o_char_we), 0);
      chk("t6_rst_addr", 32'(o_char_addr), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_after_we", 32'(o_char_we), 0);
      rd(3'd7);  chk("t6_status", 32'(cap_rdata), 0);
      rd(3'd6);  chk("t6_fill_reset", 32'(cap_rdata), 32'h20);
      wr(3'd0, 8'h50);
      chk("t6_data_wait", 32'(cap_wait), 1);
      chk("t6_data_addr", 32'(cap_char_addr), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
